// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request/response front-end.
// The response struct widths follow the FPU_unit datapath (IEEE-754 single).
package fpu_pkg;

  localparam int FPU_LAT    = 2;
  localparam int FPU_NUM_OP = 1;
  localparam int FPU_DATA_W = 32;
  localparam int FPU_TAG_W  = 4;

  typedef enum logic [FPU_NUM_OP-1:0] {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic [FPU_DATA_W-1:0] data;
    logic [FPU_TAG_W-1:0]  tag;
  } fpu_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO with a first-word-fall-through head.
// The head reads as zero while empty so downstream never sees stale data.
module fpu_rsp_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fpu_rsp_t    wdata,
  input  logic        pop,
  output fpu_rsp_t    head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  fpu_rsp_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Valid/ready front-end for a fixed-latency, non-stallable FPU_unit.
// Credits reserve a FIFO slot at issue time so every in-flight result has a home.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int NUM_OP    = FPU_NUM_OP,
  parameter int DATA_W    = FPU_DATA_W,
  parameter int TAG_W     = FPU_TAG_W,
  parameter int FPU_LAT   = fpu_pkg::FPU_LAT,
  parameter int RES_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [NUM_OP-1:0] i_req_op,
  input  logic [DATA_W-1:0] i_req_a,
  input  logic [DATA_W-1:0] i_req_b,
  input  logic [TAG_W-1:0]  i_req_tag,
  output logic [NUM_OP-1:0] o_fpu_op,
  output logic [DATA_W-1:0] o_fpu_a,
  output logic [DATA_W-1:0] o_fpu_b,
  input  logic [DATA_W-1:0] i_fpu_result,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [TAG_W-1:0]  o_rsp_tag,
  output logic              o_busy
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic [CW-1:0]      credits_reg;
  logic [CW-1:0]      credits_next;
  logic               fire;
  logic               pop;
  logic               push;
  fpu_rsp_t           push_data;
  fpu_rsp_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  logic [FPU_LAT-1:0] lat_vld_reg;
  logic [FPU_LAT-1:0] lat_vld_next;
  logic [TAG_W-1:0]   lat_tag_reg  [FPU_LAT];
  logic [TAG_W-1:0]   lat_tag_next [FPU_LAT];

  // FPU_unit computes every cycle; only fired requests are tracked below.
  assign o_fpu_op = i_req_op;
  assign o_fpu_a  = i_req_a;
  assign o_fpu_b  = i_req_b;

  assign o_req_ready = (credits_reg != '0);
  assign fire        = i_req_valid & o_req_ready;
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign o_busy      = (credits_reg != CW'(RES_DEPTH));

  always_comb begin
    credits_next = credits_reg;
    unique case ({fire, pop})
      2'b10:   credits_next = credits_reg - CW'(1);
      2'b01:   credits_next = credits_reg + CW'(1);
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      credits_reg <= CW'(RES_DEPTH);
    end else begin
      credits_reg <= credits_next;
    end
  end

  // Stage 0 captures the issue; the last stage lines up with i_fpu_result.
  genvar gi;
  generate
    for (gi = 0; gi < FPU_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_head
        assign lat_vld_next[gi] = fire;
        assign lat_tag_next[gi] = i_req_tag;
      end else begin : g_tail
        assign lat_vld_next[gi] = lat_vld_reg[gi-1];
        assign lat_tag_next[gi] = lat_tag_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_vld_reg <= '0;
      for (int i = 0; i < FPU_LAT; i++) begin
        lat_tag_reg[i] <= '0;
      end
    end else begin
      lat_vld_reg <= lat_vld_next;
      lat_tag_reg <= lat_tag_next;
    end
  end

  assign push           = lat_vld_reg[FPU_LAT-1];
  assign push_data.data = i_fpu_result;
  assign push_data.tag  = lat_tag_reg[FPU_LAT-1];

  fpu_rsp_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_rsp_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_data  = head.data;
  assign o_rsp_tag   = head.tag;

  // Credits plus in-flight plus queued must always account for every slot.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && fifo_full));

  a_credit_sum: assert property (@(posedge i_clk) disable iff (i_rst)
    (int'(credits_reg) + int'(fifo_count) + $countones(lat_vld_reg)) == RES_DEPTH);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with a two-stage behavioural FPU_unit stand-in.
// Expected responses are queued on each fire and compared on each pop.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [0:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic [0:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        busy;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] cur_exp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fire_cyc = 0;
  int          fire_cnt = 0;
  int          rsp_cnt = 0;
  int          stalls = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issue_ctrl #(
    .NUM_OP(1), .DATA_W(32), .TAG_W(4), .FPU_LAT(2), .RES_DEPTH(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_tag    (req_tag),
    .o_fpu_op     (fpu_op),
    .o_fpu_a      (fpu_a),
    .o_fpu_b      (fpu_b),
    .i_fpu_result (fpu_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_tag    (rsp_tag),
    .o_busy       (busy)
  );

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'h00) return 0.0;
    d = {s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          ex;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 896;
    if (d[62:0] == 63'h0 || ex <= 0) return 32'h0;
    if (ex >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmodel(input logic op, input logic [31:0] a, input logic [31:0] b);
    return r2s(op ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b)));
  endfunction

  function automatic logic [31:0] itof(input int k);
    real r;
    r = real'(k);
    return r2s(r);
  endfunction

  // FPU_unit stand-in: result of cycle-t inputs is visible during cycle t+2.
  logic [31:0] fpu_s1;
  logic [31:0] fpu_s2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_s1 <= 32'h0;
      fpu_s2 <= 32'h0;
    end else begin
      fpu_s1 <= fmodel(fpu_op[0], fpu_a, fpu_b);
      fpu_s2 <= fpu_s1;
    end
  end
  assign fpu_result = fpu_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        sb.push_back({cur_exp, req_tag});
        fire_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        $display("rsp cyc=%0d tag=%0d data=%h", cyc, rsp_tag, rsp_data);
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.d);
          check("rsp_tag", 32'(rsp_tag), 32'(e.t));
        end
      end
    end
  end

  task automatic send(input op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] exp);
    bit fired;
    fired     = 1'b0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    cur_exp   = exp;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        fired         = 1'b1;
        last_fire_cyc = cyc;
        break;
      end
      stalls++;
    end
    check("send_fired", 32'(fired), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check(tag, 32'(sb.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    int r0;
    int cnt;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    cur_exp   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single ADD with latency measurement
    @(posedge clk); #1;
    send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000);
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("add_latency", 32'(cyc - last_fire_cyc), 32'd3);
    drain("add_drain");

    // SUB and exact cancellation to zero
    @(posedge clk); #1;
    send(OP_SUB, 32'h40400000, 32'h3F800000, 4'd2, 32'h40000000);
    send(OP_ADD, 32'h3F800000, 32'hBF800000, 4'd3, 32'h00000000);
    idle();
    drain("sub_drain");

    // Eight back-to-back ADDs with the consumer always ready
    stalls = 0;
    r0     = rsp_cnt;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      send(OP_ADD, itof(k), 32'h3F800000, 4'(k), itof(k + 1));
    end
    idle();
    check("b2b_stalls", 32'(stalls), 32'd0);
    drain("b2b_drain");
    check("b2b_rsp_cnt", 32'(rsp_cnt - r0), 32'd8);

    // Consumer stalled with request held: credits run out after 4 fires
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    f0        = fire_cnt;
    req_op    = OP_ADD;
    req_a     = 32'h40000000;
    req_b     = 32'h40000000;
    req_tag   = 4'd9;
    cur_exp   = 32'h40800000;
    req_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("held_fires", 32'(fire_cnt - f0), 32'd4);
    check("held_ready", 32'(req_ready), 32'd0);
    check("held_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("after_pop_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    idle();
    drain("held_drain");

    // One credit left: simultaneous fire and pop keeps it at one
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      send(OP_ADD, itof(k), 32'h3F800000, 4'(k), itof(k + 1));
    end
    idle();
    repeat (5) @(negedge clk);
    check("c1_pre_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_a     = itof(10);
    req_b     = 32'h3F800000;
    req_tag   = 4'd4;
    cur_exp   = itof(11);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("c1_fire_pop_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("c1_hold_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_a     = itof(5);
    req_tag   = 4'd6;
    cur_exp   = itof(6);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("c1_last_credit", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("c1_drain");

    // Reset with two results queued and two in flight
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int k = 10; k < 14; k++) begin
      send(OP_ADD, itof(k), 32'h3F800000, 4'(k), itof(k + 1));
    end
    idle();
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    cnt       = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("post_rst_no_rsp", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    send(OP_SUB, 32'h40A00000, 32'h3F800000, 4'd7, 32'h40800000);
    idle();
    drain("post_rst_drain");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
